// File: rtl/set_scan_pkg.sv
// set_scan_pkg: mode and FSM encodings shared by the set_scan block.
package set_scan_pkg;

  // Combination rule applied across the circle sets for each point.
  localparam logic [1:0] MODE_AND  = 2'd0; // inside every set
  localparam logic [1:0] MODE_OR   = 2'd1; // inside at least one set
  localparam logic [1:0] MODE_XOR1 = 2'd2; // inside exactly one set
  localparam logic [1:0] MODE_DIFF = 2'd3; // inside set 0 and no other set

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/set_row_member.sv
// set_row_member: membership of every point on one grid row in one circle.
// A point is inside when r != 0 and dx^2 + dy^2 <= r^2, evaluated exactly.
module set_row_member #(
  parameter int GRID    = 8,
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [COORD_W-1:0] r_i,
  output logic [GRID-1:0]    member_o
);

  // Squares are formed at this width so dx^2 + dy^2 never wraps.
  localparam int SQ_W = 2 * COORD_W + 2;

  logic [SQ_W-1:0] dy_sq;
  logic [SQ_W-1:0] r_sq;
  logic [COORD_W-1:0] dy_abs;

  assign dy_abs = (y_i >= cy_i) ? (y_i - cy_i) : (cy_i - y_i);
  assign dy_sq  = SQ_W'(dy_abs) * SQ_W'(dy_abs);
  assign r_sq   = SQ_W'(r_i) * SQ_W'(r_i);

  for (genvar gx = 0; gx < GRID; gx++) begin : g_col
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] dx_abs;
    logic [SQ_W-1:0]    dist_sq;

    assign x_pos   = COORD_W'(gx);
    assign dx_abs  = (x_pos >= cx_i) ? (x_pos - cx_i) : (cx_i - x_pos);
    assign dist_sq = SQ_W'(dx_abs) * SQ_W'(dx_abs) + dy_sq;
    assign member_o[gx] = (r_i != '0) && (dist_sq <= r_sq);
  end

endmodule

// File: rtl/set_scan.sv
// set_scan: counts grid points that satisfy a set-combination rule over
// NUM_SET circles, scanning one row per cycle.
// Optional macro SET_SCAN_PIPE_EN registers the per-row hit vector before the
// popcount/accumulate stage, adding one cycle of latency.
// Handshake: en is a start strobe accepted only in IDLE or DONE; valid is a
// one-cycle strobe in DONE and candidate holds the result until the next job
// completes (or reset).
module set_scan
  import set_scan_pkg::*;
#(
  parameter int GRID    = 8,
  parameter int NUM_SET = 3,
  parameter int COORD_W = 4,
  parameter int CNT_W   = $clog2(GRID * GRID + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_SET*2*COORD_W-1:0]   central,
  input  logic [NUM_SET*COORD_W-1:0]     radius,
  input  logic [1:0]                     mode,
  output logic                           busy,
  output logic                           valid,
  output logic [CNT_W-1:0]               candidate,
  output logic [1:0]                     state_dbg_o
);

  localparam int PH_W = $clog2(GRID + 2);
  localparam logic [PH_W-1:0] PH_ROWS = PH_W'(GRID);
`ifdef SET_SCAN_PIPE_EN
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(GRID + 1);
`else
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(GRID);
`endif

  state_e                         state_q, state_d;
  logic [PH_W-1:0]                ph_q, ph_d;
  logic [NUM_SET*2*COORD_W-1:0]   cen_q, cen_d;
  logic [NUM_SET*COORD_W-1:0]     rad_q, rad_d;
  logic [1:0]                     mode_q, mode_d;
  logic [CNT_W-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]               cand_q, cand_d;

  logic [COORD_W-1:0] row_y;
  logic [GRID-1:0]    member [NUM_SET];
  logic [GRID-1:0]    row_hit;
  logic [GRID-1:0]    pop_src;
  logic [CNT_W-1:0]   row_pop;
  logic               row_live;

  assign row_y    = COORD_W'(ph_q);
  assign row_live = (state_q == CALC) && (ph_q < PH_ROWS);

  for (genvar gi = 0; gi < NUM_SET; gi++) begin : g_set
    localparam int CB = (NUM_SET - 1 - gi) * 2 * COORD_W;
    localparam int RB = (NUM_SET - 1 - gi) * COORD_W;
    set_row_member #(.GRID(GRID), .COORD_W(COORD_W)) u_member (
      .y_i      (row_y),
      .cx_i     (cen_q[CB + 2*COORD_W - 1 -: COORD_W]),
      .cy_i     (cen_q[CB + COORD_W - 1 -: COORD_W]),
      .r_i      (rad_q[RB + COORD_W - 1 -: COORD_W]),
      .member_o (member[gi])
    );
  end

  // Apply the latched mode to each column of the current row.
  always_comb begin
    row_hit = '0;
    for (int c = 0; c < GRID; c++) begin
      logic       all_in, others;
      logic [2:0] ones;
      all_in = 1'b1;
      others = 1'b0;
      ones   = '0;
      for (int i = 0; i < NUM_SET; i++) begin
        all_in = all_in & member[i][c];
        ones   = ones + 3'(member[i][c]);
        if (i != 0) others = others | member[i][c];
      end
      case (mode_q)
        MODE_AND:  row_hit[c] = all_in;
        MODE_OR:   row_hit[c] = (ones != '0);
        MODE_XOR1: row_hit[c] = (ones == 3'd1);
        default:   row_hit[c] = member[0][c] & ~others;
      endcase
    end
  end

`ifdef SET_SCAN_PIPE_EN
  logic [GRID-1:0] mem_q, mem_d;

  assign mem_d   = row_live ? row_hit : '0;
  assign pop_src = mem_q;

  // Row hit register between compare and accumulate.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end
`else
  assign pop_src = row_live ? row_hit : '0;
`endif

  // Popcount of the row entering the accumulator.
  always_comb begin
    row_pop = '0;
    for (int c = 0; c < GRID; c++) row_pop = row_pop + CNT_W'(pop_src[c]);
  end

  // Next-state, job latching and accumulation.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cen_d   = cen_q;
    rad_d   = rad_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cand_d  = cand_q;
    case (state_q)
      CALC: begin
        acc_d = acc_q + row_pop;
        ph_d  = ph_q + 1'b1;
        if (ph_q == PH_LAST) begin
          state_d = DONE;
          cand_d  = acc_d;
        end
      end
      default: begin
        // IDLE and DONE accept a new job; DONE otherwise drops to IDLE.
        if (state_q == DONE) state_d = IDLE;
        if (en) begin
          state_d = CALC;
          ph_d    = '0;
          acc_d   = '0;
          cen_d   = central;
          rad_d   = radius;
          mode_d  = mode;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      cen_q   <= '0;
      rad_q   <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cen_q   <= cen_d;
      rad_q   <= rad_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign valid       = (state_q == DONE);
  assign candidate   = cand_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_set_scan.sv
// tb_set_scan: directed jobs with hand-computed counts; a monitor pops the
// expected queue whenever valid is seen and also checks valid latency.
module tb_set_scan;

  localparam int GRID    = 8;
  localparam int NUM_SET = 3;
  localparam int COORD_W = 4;
  localparam int CNT_W   = $clog2(GRID * GRID + 1);
  localparam int PERIOD  = 10;
`ifdef SET_SCAN_PIPE_EN
  localparam int LAT = GRID + 3;
`else
  localparam int LAT = GRID + 2;
`endif

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         en;
  logic [NUM_SET*2*COORD_W-1:0] central;
  logic [NUM_SET*COORD_W-1:0]   radius;
  logic [1:0]                   mode;
  logic                         busy;
  logic                         valid;
  logic [CNT_W-1:0]             candidate;
  logic [1:0]                   state_dbg;

  logic [CNT_W-1:0] exp_q[$];
  time              t_q[$];
  int               n_pass  = 0;
  int               n_total = 0;
  int               n_valid = 0;

  set_scan #(.GRID(GRID), .NUM_SET(NUM_SET), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .central     (central),
    .radius      (radius),
    .mode        (mode),
    .busy        (busy),
    .valid       (valid),
    .candidate   (candidate),
    .state_dbg_o (state_dbg)
  );

  // Clock
  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [23:0] pk_c(input logic [3:0] x0, y0, x1, y1, x2, y2);
    return {x0, y0, x1, y1, x2, y2};
  endfunction

  function automatic logic [11:0] pk_r(input logic [3:0] r0, r1, r2);
    return {r0, r1, r2};
  endfunction

  // Scoreboard monitor: every valid pops one expected count.
  always @(negedge clk) begin
    if (rst && valid) begin
      logic [CNT_W-1:0] e;
      time              t;
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(candidate), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        t = t_q.pop_front();
        check("candidate", 32'(candidate), 32'(e));
        check("latency", 32'(($time - t) / PERIOD), 32'(LAT));
      end
    end
  end

  // Driver: call at a negedge; leaves en low one negedge later.
  task automatic issue(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                       input logic [CNT_W-1:0] exp, input bit push);
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      t_q.push_back($time);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_hold(input logic [CNT_W-1:0] exp);
    @(negedge clk);
    check("hold_candidate", 32'(candidate), 32'(exp));
    check("hold_valid_low", 32'(valid), 32'd0);
    check("hold_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input logic [CNT_W-1:0] exp);
    @(negedge clk);
    issue(c, r, m, exp, 1'b1);
    wait_valid("valid_seen");
    check_hold(exp);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    central = '0;
    radius = '0;
    mode = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_candidate", 32'(candidate), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b1;

    // Single-set style patterns.
    run_job(pk_c(3,3,3,3,3,3), pk_r(1,1,1), 2'd0, 5);
    run_job(pk_c(0,0,0,0,0,0), pk_r(1,1,1), 2'd1, 3);
    run_job(pk_c(0,0,7,7,7,7), pk_r(1,1,1), 2'd2, 3);
    run_job(pk_c(3,3,3,3,0,0), pk_r(2,1,0), 2'd3, 8);
    run_job(pk_c(4,4,4,4,4,4), pk_r(15,15,15), 2'd0, 64);
    run_job(pk_c(0,0,7,7,3,3), pk_r(1,1,1), 2'd1, 11);
    run_job(pk_c(3,3,3,4,0,0), pk_r(1,1,0), 2'd2, 6);
    run_job(pk_c(3,3,3,3,3,3), pk_r(1,1,0), 2'd0, 0);

    // en during CALC is ignored; original job completes unchanged.
    @(negedge clk);
    issue(pk_c(3,3,3,3,3,3), pk_r(1,1,1), 2'd0, 5, 1'b1);
    repeat (2) @(negedge clk);
    issue(pk_c(4,4,4,4,4,4), pk_r(15,15,15), 2'd0, 64, 1'b0);
    wait_valid("valid_seen_ignore");
    check_hold(5);

    // en during DONE starts the next job back to back.
    @(negedge clk);
    issue(pk_c(0,0,0,0,0,0), pk_r(1,1,1), 2'd1, 3, 1'b1);
    wait_valid("valid_seen_b2b_first");
    issue(pk_c(3,3,3,3,0,0), pk_r(2,1,0), 2'd3, 8, 1'b1);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid_low", 32'(valid), 32'd0);
    check("b2b_state_calc", 32'(state_dbg), 32'd1);
    wait_valid("valid_seen_b2b_second");
    check_hold(8);

    // Reset mid-CALC abandons the job.
    @(negedge clk);
    issue(pk_c(4,4,4,4,4,4), pk_r(15,15,15), 2'd0, 64, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_candidate", 32'(candidate), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    begin
      int v0;
      v0 = n_valid;
      rst = 1'b1;
      repeat (GRID + 6) @(negedge clk);
      check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
